// File: rtl/led_gs_packer.sv
// Packs 16 RGB pixels into a 769-bit grayscale latch word, double-buffered.
// Build with LED_GS_GAMMA_EN for gamma-2 (p*p) expansion, else {p,p}.
module led_gs_packer #(
  parameter int NUM_LEDS   = 16,
  parameter int PIX_W      = 8,
  parameter int LATCH_SIZE = 769
) (
  input  logic                  PIXCLK,
  input  logic                  nReset,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_W-1:0]      pix_r,
  input  logic [PIX_W-1:0]      pix_g,
  input  logic [PIX_W-1:0]      pix_b,
  input  logic                  pix_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LATCH_SIZE-1:0] out_data,
  output logic                  out_sof,
  output logic                  err_partial
);

  localparam int GS_W  = 2 * PIX_W;
  localparam int LED_W = 3 * GS_W;
  localparam int BUF_W = LATCH_SIZE - 1;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_LEDS);

  logic [BUF_W-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fsof_q, fsof_d;
  logic                  ov_q, ov_d;
  logic [LATCH_SIZE-1:0] od_q, od_d;
  logic                  os_q, os_d;
  logic                  err_q, err_d;

  logic             full;
  logic             accept;
  logic             xfer;
  logic [LED_W-1:0] px;

  function automatic logic [GS_W-1:0] expand(
    input logic [PIX_W-1:0] p
  );
`ifdef LED_GS_GAMMA_EN
    return GS_W'(p) * GS_W'(p);
`else
    return {p, p};
`endif
  endfunction

  assign full      = (cnt_q == FULL);
  assign pix_ready = !full;
  assign accept    = pix_valid && pix_ready;
  assign xfer      = full && (!ov_q || out_ready);
  assign px        = {expand(pix_b),
                      expand(pix_g),
                      expand(pix_r)};

  always_comb begin
    fill_d = fill_q;
    cnt_d  = cnt_q;
    fsof_d = fsof_q;
    ov_d   = ov_q;
    od_d   = od_q;
    os_d   = os_q;
    err_d  = 1'b0;

    // Top bit is the latch select, always 0.
    if (xfer) begin
      od_d   = {1'b0, fill_q};
      os_d   = fsof_q;
      ov_d   = 1'b1;
      fill_d = '0;
      cnt_d  = '0;
      fsof_d = 1'b0;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end

    if (accept) begin
      if (pix_sof) begin
        err_d              = (cnt_q != '0);
        fill_d             = '0;
        fill_d[0 +: LED_W] = px;
        cnt_d              = CNT_W'(1);
        fsof_d             = 1'b1;
      end else begin
        for (int k = 0; k < NUM_LEDS; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            fill_d[k*LED_W +: LED_W] = px;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge PIXCLK or negedge nReset) begin
    if (!nReset) begin
      fill_q <= '0;
      cnt_q  <= '0;
      fsof_q <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      os_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      fsof_q <= fsof_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      os_q   <= os_d;
      err_q  <= err_d;
    end
  end

  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign out_sof     = os_q;
  assign err_partial = err_q;

endmodule

// File: tb/tb_led_gs_packer.sv
// Bench for led_gs_packer: queue-based word model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_led_gs_packer;

  localparam int LS = 769;

  logic          PIXCLK = 1'b0;
  logic          nReset = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [7:0]    pix_r = '0;
  logic [7:0]    pix_g = '0;
  logic [7:0]    pix_b = '0;
  logic          pix_sof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LS-1:0] out_data;
  logic          out_sof;
  logic          err_partial;

  always #5 PIXCLK = ~PIXCLK;

  led_gs_packer dut (
    .PIXCLK      (PIXCLK),
    .nReset      (nReset),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .pix_sof     (pix_sof),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .err_partial (err_partial)
  );

  int checks = 0;
  int errors = 0;

  // Model: list of pixels in the word being filled, plus the held output.
  logic [47:0]   m_fill[$];
  bit            m_fsof;
  bit            m_ov;
  bit            m_os;
  bit            m_err;
  logic [LS-1:0] m_od;

  function automatic logic [15:0] gs(input logic [7:0] p);
    int v;
    v = int'(p);
`ifdef LED_GS_GAMMA_EN
    return 16'(v * v);
`else
    return 16'(v * 257);
`endif
  endfunction

  function automatic logic [LS-1:0] pack_word();
    logic [LS-1:0] w;
    w = '0;
    foreach (m_fill[k]) w = w | (LS'(m_fill[k]) << (48 * k));
    return w;
  endfunction

  task automatic model_step();
    bit acc;
    bit xf;
    acc = pix_valid && (m_fill.size() != 16);
    xf  = (m_fill.size() == 16) && (!m_ov || out_ready);
    m_err = 1'b0;
    if (xf) begin
      m_od = pack_word();
      m_os = m_fsof;
      m_ov = 1'b1;
      m_fill.delete();
      m_fsof = 1'b0;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    if (acc) begin
      if (pix_sof) begin
        m_err = (m_fill.size() != 0);
        m_fill.delete();
        m_fsof = 1'b1;
      end
      m_fill.push_back({gs(pix_b), gs(pix_g), gs(pix_r)});
    end
  endtask

  initial begin
    forever begin
      @(posedge PIXCLK or negedge nReset);
      if (!nReset) begin
        m_fill.delete();
        m_fsof = 1'b0;
        m_ov   = 1'b0;
        m_os   = 1'b0;
        m_err  = 1'b0;
        m_od   = '0;
      end else begin
        model_step();
      end
    end
  end

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", n, a, e, $time);
    end
  endtask

  task automatic chkw(input string n, input logic [LS-1:0] a,
                      input logic [LS-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, a, e, $time);
    end
  endtask

  task automatic compare();
    chk1("pix_ready", pix_ready, m_fill.size() != 16);
    chk1("out_valid", out_valid, m_ov);
    chk1("err_partial", err_partial, m_err);
    if (m_ov) begin
      chk1("out_sof", out_sof, m_os);
      chkw("out_data", out_data, m_od);
    end
  endtask

  task automatic tick();
    @(negedge PIXCLK);
    compare();
    #1;
  endtask

  task automatic put(input bit v, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b,
                     input bit s);
    pix_valid = v;
    pix_r     = r;
    pix_g     = g;
    pix_b     = b;
    pix_sof   = s;
  endtask

  task automatic do_reset();
    nReset    = 1'b0;
    out_ready = 1'b0;
    put(0, 8'h00, 8'h00, 8'h00, 0);
    tick();
    tick();
    nReset = 1'b1;
  endtask

  initial begin
    logic [47:0] grp;
    logic [15:0] r45;
    logic [15:0] r20;
    int acc;
    int lows;
    int words;
    int errs;

`ifdef LED_GS_GAMMA_EN
    grp = 48'h4000_0000_FE01;
    r45 = 16'h1299;
    r20 = 16'h0400;
`else
    grp = 48'h8080_0000_FFFF;
    r45 = 16'h4545;
    r20 = 16'h2020;
`endif

    // Reset state
    do_reset();
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_ready", pix_ready, 1'b1);
    chk1("rst_err", err_partial, 1'b0);
    chk1("rst_sof", out_sof, 1'b0);
    chkw("rst_data", out_data, '0);

    // Uniform word, latency and field layout
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put(1, 8'hFF, 8'h00, 8'h80, i == 0);
      tick();
    end
    put(0, 8'h00, 8'h00, 8'h00, 0);
    chk1("lat_early", out_valid, 1'b0);
    tick();
    chk1("lat_valid", out_valid, 1'b1);
    chkw("grp0", LS'(out_data[47:0]), LS'(grp));
    chkw("grp15", LS'(out_data[767:720]), LS'(grp));
    chk1("latch_bit", out_data[768], 1'b0);
    chk1("t1_sof", out_sof, 1'b1);
    tick();

    // Backpressure: two words buffered, then drain
    do_reset();
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      put(1, 8'(i), 8'(i + 1), 8'(i + 2), 0);
      if (pix_ready) acc++;
      tick();
    end
    chki("bp_accepts", acc, 32);
    chk1("bp_ready_low", pix_ready, 1'b0);
    put(0, 8'h00, 8'h00, 8'h00, 0);
    out_ready = 1'b1;
    tick();
    chk1("bp_word2", out_valid, 1'b1);
    chk1("bp_resume", pix_ready, 1'b1);
    tick();
    chk1("bp_drain", out_valid, 1'b0);

    // sof on the 6th pixel discards the partial word
    do_reset();
    out_ready = 1'b1;
    errs  = 0;
    words = 0;
    for (int i = 0; i < 21; i++) begin
      put(1, 8'(8'h40 + i), 8'h00, 8'h00, (i == 0) || (i == 5));
      tick();
      if (err_partial) errs++;
      if (out_valid) words++;
    end
    chki("sof_no_word", words, 0);
    put(0, 8'h00, 8'h00, 8'h00, 0);
    tick();
    if (err_partial) errs++;
    chk1("sof_valid", out_valid, 1'b1);
    chk1("sof_flag", out_sof, 1'b1);
    chkw("sof_led0", LS'(out_data[15:0]), LS'(r45));
    tick();
    chki("sof_err_pulses", errs, 1);

    // Reset with a word pending and a partial fill
    do_reset();
    for (int i = 0; i < 27; i++) begin
      put(1, 8'hAA, 8'h55, 8'h11, 0);
      tick();
    end
    chk1("pend_valid", out_valid, 1'b1);
    put(0, 8'h00, 8'h00, 8'h00, 0);
    nReset = 1'b0;
    #1;
    chk1("arst_valid", out_valid, 1'b0);
    chk1("arst_ready", pix_ready, 1'b1);
    tick();
    nReset    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put(1, 8'h20, 8'h00, 8'h00, 0);
      tick();
    end
    put(0, 8'h00, 8'h00, 8'h00, 0);
    tick();
    chk1("clean_valid", out_valid, 1'b1);
    chkw("clean_grp0", LS'(out_data[47:0]), LS'({32'h0, r20}));
    chkw("clean_grp15", LS'(out_data[767:720]), LS'({32'h0, r20}));
    chk1("clean_sof", out_sof, 1'b0);
    tick();

    // Sustained stream of 64 pixels
    do_reset();
    out_ready = 1'b1;
    acc   = 0;
    lows  = 0;
    words = 0;
    for (int i = 0; i < 200 && acc < 64; i++) begin
      put(1, 8'(acc), 8'(acc + 100), 8'(255 - acc), 0);
      if (pix_ready) acc++;
      else lows++;
      tick();
      if (out_valid) begin
        chkw("idx_led0", LS'(out_data[15:0]),
             LS'(gs(8'(16 * words))));
        chkw("idx_led15", LS'(out_data[735:720]),
             LS'(gs(8'(16 * words + 15))));
        words++;
      end
    end
    put(0, 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      if (!pix_ready) lows++;
      tick();
      if (out_valid) words++;
    end
    chki("stream_accepts", acc, 64);
    chki("stream_words", words, 4);
    chki("stream_ready_low", lows, 4);

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      put($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
          8'($urandom), $urandom_range(0, 19) == 0);
      out_ready = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 599) == 0) begin
        nReset = 1'b0;
        #1;
        tick();
        nReset = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
